// File: rtl/fb_fill_engine.sv
// Rectangle fill engine writing packed 8-bit pixels (4 per word) into a framebuffer BRAM port.
// Define FB_FILL_CLIP_EN to clip rectangles to the framebuffer instead of rejecting them.
module fb_fill_engine #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [8:0]  cmd_y0,
    input  logic [9:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic        cmd_err,
    output logic        bram_clka,
    output logic        bram_rsta,
    output logic        bram_ena,
    output logic [3:0]  bram_wea,
    output logic [16:0] bram_addra,
    output logic [31:0] bram_dina
);

    localparam logic [16:0] WPR   = 17'(H_RES / 4);
    localparam logic [10:0] X_LIM = 11'(H_RES);
    localparam logic [9:0]  Y_LIM = 10'(V_RES);
`ifdef FB_FILL_CLIP_EN
    localparam logic [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_RES - 1);
`endif

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x0_q, x0_d;
    logic [8:0]  y0_q, y0_d;
    logic [9:0]  w_q, w_d;
    logic [8:0]  h_q, h_d;
    logic [7:0]  color_q, color_d;
    logic [7:0]  x0w_q, x0w_d;
    logic [7:0]  x1w_q, x1w_d;
    logic [7:0]  xw_q, xw_d;
    logic [8:0]  y_q, y_d;
    logic [8:0]  y1_q, y1_d;
    logic [3:0]  lmask_q, lmask_d;
    logic [3:0]  rmask_q, rmask_d;
    logic [16:0] base_q, base_d;
    logic        reject_q, reject_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ena_q, ena_d;
    logic [3:0]  wea_q, wea_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] dina_q, dina_d;

    logic        setup_empty;
    logic        setup_reject;
    logic [9:0]  setup_x1;
    logic [8:0]  setup_y1;

    // y * (H_RES/4) as a sum of shifted copies of y, one per set bit of the constant
    function automatic logic [16:0] row_offset(input logic [8:0] y);
        logic [16:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 17; i++) begin
            if (WPR[i]) acc = acc + ({8'b0, y} << i);
        end
        return acc;
    endfunction

`ifdef FB_FILL_CLIP_EN
    logic [10:0] x_end;
    logic [9:0]  y_end;

    always_comb begin
        x_end        = {1'b0, x0_q} + {1'b0, w_q} - 11'd1;
        y_end        = {1'b0, y0_q} + {1'b0, h_q} - 10'd1;
        setup_empty  = (w_q == '0) || (h_q == '0) ||
                       ({1'b0, x0_q} >= X_LIM) || ({1'b0, y0_q} >= Y_LIM);
        setup_reject = 1'b0;
        setup_x1     = (x_end > X_MAX) ? X_MAX[9:0] : x_end[9:0];
        setup_y1     = (y_end > Y_MAX) ? Y_MAX[8:0] : y_end[8:0];
    end
`else
    logic [10:0] x_sum;
    logic [9:0]  y_sum;

    always_comb begin
        x_sum        = {1'b0, x0_q} + {1'b0, w_q};
        y_sum        = {1'b0, y0_q} + {1'b0, h_q};
        setup_empty  = (w_q == '0) || (h_q == '0);
        setup_reject = !setup_empty && ((x_sum > X_LIM) || (y_sum > Y_LIM));
        setup_x1     = x0_q + w_q - 10'd1;
        setup_y1     = y0_q + h_q - 9'd1;
    end
`endif

    // The done/err pulse trails the DONE state by one register stage, so busy
    // stays high through the pulse and a new command is taken only afterwards.
    assign busy       = (state_q != IDLE) | done_q | err_q;
    assign cmd_ready  = ~busy;
    assign done       = done_q;
    assign cmd_err    = err_q;
    assign bram_clka  = clk;
    assign bram_rsta  = reset;
    assign bram_ena   = ena_q;
    assign bram_wea   = wea_q;
    assign bram_addra = addr_q;
    assign bram_dina  = dina_q;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        x0w_d    = x0w_q;
        x1w_d    = x1w_q;
        xw_d     = xw_q;
        y_d      = y_q;
        y1_d     = y1_q;
        lmask_d  = lmask_q;
        rmask_d  = rmask_q;
        base_d   = base_q;
        reject_d = reject_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ena_d    = 1'b0;
        wea_d    = '0;
        addr_d   = addr_q;
        dina_d   = dina_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                x0w_d    = x0_q[9:2];
                x1w_d    = setup_x1[9:2];
                xw_d     = x0_q[9:2];
                y_d      = y0_q;
                y1_d     = setup_y1;
                lmask_d  = 4'b1111 << x0_q[1:0];
                rmask_d  = 4'b1111 >> (2'd3 - setup_x1[1:0]);
                base_d   = row_offset(y0_q);
                reject_d = setup_reject;
                state_d  = (setup_empty || setup_reject) ? DONE : WRITE;
            end
            WRITE: begin
                ena_d  = 1'b1;
                wea_d  = ((xw_q == x0w_q) ? lmask_q : 4'b1111) &
                         ((xw_q == x1w_q) ? rmask_q : 4'b1111);
                addr_d = base_q + {9'b0, xw_q};
                dina_d = {4{color_q}};
                if (xw_q == x1w_q) begin
                    if (y_q == y1_q) begin
                        state_d = DONE;
                    end else begin
                        y_d    = y_q + 9'd1;
                        base_d = base_q + WPR;
                        xw_d   = x0w_q;
                    end
                end else begin
                    xw_d = xw_q + 8'd1;
                end
            end
            DONE: begin
                done_d  = ~reject_q;
                err_d   = reject_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            x0w_q    <= '0;
            x1w_q    <= '0;
            xw_q     <= '0;
            y_q      <= '0;
            y1_q     <= '0;
            lmask_q  <= '0;
            rmask_q  <= '0;
            base_q   <= '0;
            reject_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ena_q    <= 1'b0;
            wea_q    <= '0;
            addr_q   <= '0;
            dina_q   <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            color_q  <= color_d;
            x0w_q    <= x0w_d;
            x1w_q    <= x1w_d;
            xw_q     <= xw_d;
            y_q      <= y_d;
            y1_q     <= y1_d;
            lmask_q  <= lmask_d;
            rmask_q  <= rmask_d;
            base_q   <= base_d;
            reject_q <= reject_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ena_q    <= ena_d;
            wea_q    <= wea_d;
            addr_q   <= addr_d;
            dina_q   <= dina_d;
        end
    end

endmodule
